// File: rtl/ysyx_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package ysyx_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IFU_RD = 2'd1,
        ARB_LSU_RD = 2'd2,
        ARB_LSU_WR = 2'd3
    } arb_state_e;

    localparam int         TIMER_W   = 8;
    localparam logic       GNT_IFU   = 1'b0;
    localparam logic       GNT_LSU   = 1'b1;
    localparam logic [7:0] IFU_RSTRB = 8'h0f;

    function automatic logic is_rd_state(input arb_state_e s);
        return (s == ARB_IFU_RD) || (s == ARB_LSU_RD);
    endfunction

endpackage

// File: rtl/ysyx_arb_rr2.sv
// Two-way round-robin picker: req[0]=IFU, req[1]=LSU; on a tie the master
// that did not win last time is chosen.
module ysyx_arb_rr2
    import ysyx_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    // Grant selection
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt == GNT_LSU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Shares one memory bus port between the IFU (reads) and LSU (reads/writes),
// one transaction at a time, with registered bus requests and a response watchdog.
module ysyx_mem_arbiter
    import ysyx_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rvalid,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    input  logic [7:0]        lsu_rstrb,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rvalid,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,
    output logic [ADDR_W-1:0] bus_araddr,
    output logic              bus_arvalid,
    output logic [7:0]        bus_rstrb,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rvalid,
    output logic [ADDR_W-1:0] bus_awaddr,
    output logic              bus_awvalid,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [7:0]        bus_wstrb,
    output logic              bus_wvalid,
    input  logic              bus_wready,
    output logic              arb_err
);

    localparam logic [TIMER_W-1:0] TIMEOUT_C = TIMER_W'(TIMEOUT);

    arb_state_e         state_q, state_d;
    logic               last_gnt_q, last_gnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [ADDR_W-1:0]  bus_araddr_q, bus_araddr_d, bus_awaddr_q, bus_awaddr_d;
    logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;
    logic [7:0]         bus_rstrb_q, bus_rstrb_d, bus_wstrb_q, bus_wstrb_d;
    logic               bus_arvalid_q, bus_arvalid_d, bus_wrvalid_q, bus_wrvalid_d;
    logic               lsu_wr_s, timeout_hit_s;
    logic [1:0]         gnt_s;

    assign lsu_wr_s      = lsu_awvalid & lsu_wvalid;
    assign timeout_hit_s = (TIMEOUT != 0) && (timer_q == TIMEOUT_C);

    ysyx_arb_rr2 u_rr2 (
        .req      ({lsu_arvalid | lsu_wr_s, ifu_arvalid}),
        .last_gnt (last_gnt_q),
        .gnt      (gnt_s)
    );

    // Next-state, bus register capture and combinational response forwarding
    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        timer_d      = timer_q;
        bus_araddr_d = bus_araddr_q;
        bus_rstrb_d  = bus_rstrb_q;
        bus_awaddr_d = bus_awaddr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wstrb_d  = bus_wstrb_q;
        ifu_rdata    = {DATA_W{1'b0}};
        lsu_rdata    = {DATA_W{1'b0}};
        ifu_rvalid   = 1'b0;
        lsu_rvalid   = 1'b0;
        lsu_wready   = 1'b0;
        arb_err      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                timer_d = {TIMER_W{1'b0}};
                if (gnt_s[0]) begin
                    state_d      = ARB_IFU_RD;
                    last_gnt_d   = GNT_IFU;
                    bus_araddr_d = ifu_araddr;
                    bus_rstrb_d  = IFU_RSTRB;
                end else if (gnt_s[1]) begin
                    last_gnt_d = GNT_LSU;
                    // A pending write beats a pending LSU read
                    if (lsu_wr_s) begin
                        state_d      = ARB_LSU_WR;
                        bus_awaddr_d = lsu_awaddr;
                        bus_wdata_d  = lsu_wdata;
                        bus_wstrb_d  = lsu_wstrb;
                    end else begin
                        state_d      = ARB_LSU_RD;
                        bus_araddr_d = lsu_araddr;
                        bus_rstrb_d  = lsu_rstrb;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_IFU_RD: begin
                ifu_rdata = bus_rdata;
                if (bus_rvalid) begin
                    ifu_rvalid = 1'b1;
                    state_d    = ARB_IDLE;
                end else if (timeout_hit_s) begin
                    ifu_rvalid = 1'b1;
                    ifu_rdata  = {DATA_W{1'b0}};
                    arb_err    = 1'b1;
                    state_d    = ARB_IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ARB_LSU_RD: begin
                lsu_rdata = bus_rdata;
                if (bus_rvalid) begin
                    lsu_rvalid = 1'b1;
                    state_d    = ARB_IDLE;
                end else if (timeout_hit_s) begin
                    lsu_rvalid = 1'b1;
                    lsu_rdata  = {DATA_W{1'b0}};
                    arb_err    = 1'b1;
                    state_d    = ARB_IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ARB_LSU_WR: begin
                if (bus_wready) begin
                    lsu_wready = 1'b1;
                    state_d    = ARB_IDLE;
                end else if (timeout_hit_s) begin
                    lsu_wready = 1'b1;
                    arb_err    = 1'b1;
                    state_d    = ARB_IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        bus_arvalid_d = is_rd_state(state_d);
        bus_wrvalid_d = (state_d == ARB_LSU_WR);
    end

    // State, watchdog and bus-side registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            last_gnt_q    <= GNT_LSU;
            timer_q       <= {TIMER_W{1'b0}};
            bus_araddr_q  <= {ADDR_W{1'b0}};
            bus_rstrb_q   <= 8'h00;
            bus_awaddr_q  <= {ADDR_W{1'b0}};
            bus_wdata_q   <= {DATA_W{1'b0}};
            bus_wstrb_q   <= 8'h00;
            bus_arvalid_q <= 1'b0;
            bus_wrvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_gnt_q    <= last_gnt_d;
            timer_q       <= timer_d;
            bus_araddr_q  <= bus_araddr_d;
            bus_rstrb_q   <= bus_rstrb_d;
            bus_awaddr_q  <= bus_awaddr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_wstrb_q   <= bus_wstrb_d;
            bus_arvalid_q <= bus_arvalid_d;
            bus_wrvalid_q <= bus_wrvalid_d;
        end
    end

    assign bus_araddr  = bus_araddr_q;
    assign bus_rstrb   = bus_rstrb_q;
    assign bus_arvalid = bus_arvalid_q;
    assign bus_awaddr  = bus_awaddr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_wstrb   = bus_wstrb_q;
    assign bus_awvalid = bus_wrvalid_q;
    assign bus_wvalid  = bus_wrvalid_q;

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Directed self-checking bench for ysyx_mem_arbiter (TIMEOUT=4); inputs change
// on the falling edge and outputs are sampled 1ns later.
module tb_ysyx_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr, ifu_rdata, lsu_araddr, lsu_rdata, lsu_awaddr, lsu_wdata;
    logic        ifu_arvalid, ifu_rvalid, lsu_arvalid, lsu_rvalid, lsu_awvalid, lsu_wvalid, lsu_wready;
    logic [7:0]  lsu_rstrb, lsu_wstrb, bus_rstrb, bus_wstrb;
    logic [31:0] bus_araddr, bus_rdata, bus_awaddr, bus_wdata;
    logic        bus_arvalid, bus_rvalid, bus_awvalid, bus_wvalid, bus_wready, arb_err;
    int          errors = 0;
    int          checks = 0;

    ysyx_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .bus_araddr(bus_araddr), .bus_arvalid(bus_arvalid), .bus_rstrb(bus_rstrb),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .bus_awaddr(bus_awaddr), .bus_awvalid(bus_awvalid), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_wvalid(bus_wvalid), .bus_wready(bus_wready),
        .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    task idle_inputs;
        ifu_araddr = 32'h0; ifu_arvalid = 1'b0;
        lsu_araddr = 32'h0; lsu_arvalid = 1'b0; lsu_rstrb = 8'h00;
        lsu_awaddr = 32'h0; lsu_awvalid = 1'b0; lsu_wdata = 32'h0; lsu_wstrb = 8'h00; lsu_wvalid = 1'b0;
        bus_rdata = 32'h0; bus_rvalid = 1'b0; bus_wready = 1'b0;
    endtask

    task do_reset;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task test_reset;
        idle_inputs();
        rst = 1'b1;
        ifu_arvalid = 1'b1; lsu_awvalid = 1'b1; lsu_wvalid = 1'b1; bus_rvalid = 1'b1; bus_wready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        if (bus_arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid got %b want 0", bus_arvalid); end checks++;
        if (bus_awvalid !== 1'b0 || bus_wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalids got %b%b want 00", bus_awvalid, bus_wvalid); end checks++;
        if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0 || lsu_wready !== 1'b0) begin errors++; $display("FAIL rst_resp got %b%b%b want 000", ifu_rvalid, lsu_rvalid, lsu_wready); end checks++;
        if (arb_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", arb_err); end checks++;
        idle_inputs();
        rst = 1'b0;
    endtask

    task test_ifu_alone;
        @(negedge clk);
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus_wready = (c == 2);
            if (c == 4) begin bus_rvalid = 1'b1; bus_rdata = 32'h0000_0413; end
            #1;
            if (bus_arvalid !== 1'b1) begin errors++; $display("FAIL ifu_arvalid c%0d got %b want 1", c, bus_arvalid); end checks++;
            if (bus_araddr !== 32'h8000_0000 || bus_rstrb !== 8'h0f) begin errors++; $display("FAIL ifu_addr c%0d got %h/%h want 80000000/0f", c, bus_araddr, bus_rstrb); end checks++;
            if (ifu_rvalid !== (c == 4) || lsu_wready !== 1'b0) begin errors++; $display("FAIL ifu_rvalid c%0d got %b/%b want %b/0", c, ifu_rvalid, lsu_wready, c == 4); end checks++;
        end
        if (ifu_rdata !== 32'h0000_0413) begin errors++; $display("FAIL ifu_rdata got %h want 00000413", ifu_rdata); end checks++;
        @(negedge clk);
        idle_inputs();
        #1;
        if (bus_arvalid !== 1'b0 || ifu_rvalid !== 1'b0) begin errors++; $display("FAIL ifu_done got %b/%b want 0/0", bus_arvalid, ifu_rvalid); end checks++;
    endtask

    task test_tie;
        do_reset();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0004;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_1000; lsu_rstrb = 8'h03;
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111; #1;
        if (bus_arvalid !== 1'b1 || bus_araddr !== 32'h8000_0004) begin errors++; $display("FAIL tie1_addr got %b/%h want 1/80000004", bus_arvalid, bus_araddr); end checks++;
        if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h1111_1111 || lsu_rvalid !== 1'b0 || lsu_rdata !== 32'h0) begin errors++; $display("FAIL tie1_resp got %b/%h/%b/%h want 1/11111111/0/0", ifu_rvalid, ifu_rdata, lsu_rvalid, lsu_rdata); end checks++;
        @(negedge clk);
        bus_rvalid = 1'b0; #1;
        if (bus_arvalid !== 1'b0) begin errors++; $display("FAIL tie_gap1 got %b want 0", bus_arvalid); end checks++;
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'h2222_2222; #1;
        if (bus_araddr !== 32'h8000_1000 || bus_rstrb !== 8'h03) begin errors++; $display("FAIL tie2_addr got %h/%h want 80001000/03", bus_araddr, bus_rstrb); end checks++;
        if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h2222_2222 || ifu_rvalid !== 1'b0 || ifu_rdata !== 32'h0) begin errors++; $display("FAIL tie2_resp got %b/%h/%b/%h want 1/22222222/0/0", lsu_rvalid, lsu_rdata, ifu_rvalid, ifu_rdata); end checks++;
        @(negedge clk);
        bus_rvalid = 1'b0; #1;
        if (bus_arvalid !== 1'b0) begin errors++; $display("FAIL tie_gap2 got %b want 0", bus_arvalid); end checks++;
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'h3333_3333; #1;
        if (bus_araddr !== 32'h8000_0004 || bus_rstrb !== 8'h0f || ifu_rvalid !== 1'b1) begin errors++; $display("FAIL tie3 got %h/%h/%b want 80000004/0f/1", bus_araddr, bus_rstrb, ifu_rvalid); end checks++;
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
        @(negedge clk);
        idle_inputs();
    endtask

    task test_lsu_write;
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1; lsu_awaddr = 32'ha000_03f8; lsu_wdata = 32'h41; lsu_wstrb = 8'h01;
        @(negedge clk); #1;
        if (bus_awvalid !== 1'b1 || bus_wvalid !== 1'b1 || bus_arvalid !== 1'b0) begin errors++; $display("FAIL wr_valids got %b%b%b want 110", bus_awvalid, bus_wvalid, bus_arvalid); end checks++;
        if (bus_awaddr !== 32'ha000_03f8 || bus_wdata !== 32'h41 || bus_wstrb !== 8'h01) begin errors++; $display("FAIL wr_latch got %h/%h/%h want a00003f8/00000041/01", bus_awaddr, bus_wdata, bus_wstrb); end checks++;
        if (lsu_wready !== 1'b0) begin errors++; $display("FAIL wr_early got %b want 0", lsu_wready); end checks++;
        @(negedge clk);
        bus_wready = 1'b1; bus_rvalid = 1'b1; #1;
        if (lsu_wready !== 1'b1 || ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0 || arb_err !== 1'b0) begin errors++; $display("FAIL wr_resp got %b/%b/%b/%b want 1/0/0/0", lsu_wready, ifu_rvalid, lsu_rvalid, arb_err); end checks++;
        @(negedge clk);
        idle_inputs(); #1;
        if (bus_awvalid !== 1'b0 || lsu_wready !== 1'b0) begin errors++; $display("FAIL wr_done got %b/%b want 0/0", bus_awvalid, lsu_wready); end checks++;
    endtask

    task test_wr_over_rd;
        lsu_arvalid = 1'b1; lsu_araddr = 32'ha000_0200; lsu_rstrb = 8'hf0;
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1; lsu_awaddr = 32'ha000_0100; lsu_wdata = 32'hdead_beef; lsu_wstrb = 8'h0f;
        @(negedge clk); #1;
        if (bus_awvalid !== 1'b1 || bus_arvalid !== 1'b0 || bus_wdata !== 32'hdead_beef) begin errors++; $display("FAIL wvr_first got %b/%b/%h want 1/0/deadbeef", bus_awvalid, bus_arvalid, bus_wdata); end checks++;
        @(negedge clk);
        bus_wready = 1'b1; #1;
        if (lsu_wready !== 1'b1) begin errors++; $display("FAIL wvr_wready got %b want 1", lsu_wready); end checks++;
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        @(negedge clk);
        bus_wready = 1'b0; #1;
        if (bus_awvalid !== 1'b0 || bus_arvalid !== 1'b0) begin errors++; $display("FAIL wvr_gap got %b/%b want 0/0", bus_awvalid, bus_arvalid); end checks++;
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'h0000_0033; #1;
        if (bus_arvalid !== 1'b1 || bus_araddr !== 32'ha000_0200 || bus_rstrb !== 8'hf0) begin errors++; $display("FAIL wvr_rd got %b/%h/%h want 1/a0000200/f0", bus_arvalid, bus_araddr, bus_rstrb); end checks++;
        if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h0000_0033) begin errors++; $display("FAIL wvr_rdata got %b/%h want 1/00000033", lsu_rvalid, lsu_rdata); end checks++;
        lsu_arvalid = 1'b0;
        @(negedge clk);
        idle_inputs();
    endtask

    task test_timeout;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0008; bus_rdata = 32'hffff_ffff;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            if (bus_arvalid !== 1'b1 || arb_err !== 1'b0 || ifu_rvalid !== 1'b0) begin errors++; $display("FAIL to_wait c%0d got %b/%b/%b want 1/0/0", c, bus_arvalid, arb_err, ifu_rvalid); end checks++;
        end
        @(negedge clk); #1;
        if (arb_err !== 1'b1 || ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0 || lsu_rvalid !== 1'b0) begin errors++; $display("FAIL to_abort got %b/%b/%h/%b want 1/1/00000000/0", arb_err, ifu_rvalid, ifu_rdata, lsu_rvalid); end checks++;
        ifu_arvalid = 1'b0;
        @(negedge clk); #1;
        if (bus_arvalid !== 1'b0 || arb_err !== 1'b0) begin errors++; $display("FAIL to_idle got %b/%b want 0/0", bus_arvalid, arb_err); end checks++;
        @(negedge clk);
        bus_rvalid = 1'b1; #1;
        if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0 || ifu_rdata !== 32'h0) begin errors++; $display("FAIL to_late got %b/%b/%h want 0/0/0", ifu_rvalid, lsu_rvalid, ifu_rdata); end checks++;
        @(negedge clk);
        idle_inputs();
    endtask

    task test_timeout_race;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_000c;
        repeat (4) @(negedge clk);
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'h0000_5aa5; #1;
        if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_5aa5 || arb_err !== 1'b0) begin errors++; $display("FAIL race got %b/%h/%b want 1/00005aa5/0", ifu_rvalid, ifu_rdata, arb_err); end checks++;
        ifu_arvalid = 1'b0;
        @(negedge clk);
        idle_inputs();
    endtask

    task test_reset_mid;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_2000; lsu_rstrb = 8'h0f;
        @(negedge clk); #1;
        if (bus_arvalid !== 1'b1 || bus_araddr !== 32'h8000_2000) begin errors++; $display("FAIL rm_busy got %b/%h want 1/80002000", bus_arvalid, bus_araddr); end checks++;
        rst = 1'b1; lsu_arvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0; #1;
        if (bus_arvalid !== 1'b0) begin errors++; $display("FAIL rm_arvalid got %b want 0", bus_arvalid); end checks++;
        bus_rvalid = 1'b1; bus_rdata = 32'h0000_0055; #1;
        if (lsu_rvalid !== 1'b0 || lsu_rdata !== 32'h0 || ifu_rvalid !== 1'b0) begin errors++; $display("FAIL rm_stale got %b/%h/%b want 0/0/0", lsu_rvalid, lsu_rdata, ifu_rvalid); end checks++;
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ifu_alone();
        test_tie();
        test_lsu_write();
        test_wr_over_rd();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
